// File: rtl/uart_hex_digest_rx_pkg.sv
// Shared definitions for the ASCII-hex digest receive path: line-control
// characters and the parser state encoding.
package uart_hex_digest_rx_pkg;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_DRAIN   = 1'b1
  } state_t;

endpackage

// File: rtl/uart_hex_digest_rx_ascii_hex_nibble.sv
// Combinational ASCII hex digit decoder: '0'-'9', 'a'-'f', 'A'-'F' -> 0..15.
// Zero latency; no flow control.
module ascii_hex_nibble (
  input  logic [7:0] ch,
  output logic [3:0] nib,
  output logic       is_hex
);

  always_comb begin
    nib    = 4'd0;
    is_hex = 1'b0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      nib    = ch[3:0];
      is_hex = 1'b1;
    end else if ((ch >= 8'h61 && ch <= 8'h66) || (ch >= 8'h41 && ch <= 8'h46)) begin
      // Low nibble of 'a'/'A' is 1, so +9 lands on 10.
      nib    = ch[3:0] + 4'd9;
      is_hex = 1'b1;
    end
  end

endmodule

// File: rtl/uart_hex_digest_rx.sv
// Assembles NCHARS ASCII hex digits (MSN first, LF-terminated) from UART RX bytes into a value.
// Results/errors registered 1 clock after the rx_done rising edge; no backpressure, bytes are never stalled.
module uart_hex_digest_rx
  import uart_hex_digest_rx_pkg::*;
#(
  parameter int          NCHARS  = 64,
  parameter logic [31:0] TIMEOUT = 32'd50_000_000,
  localparam int         DATA_W  = NCHARS * 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              rx_done,
  input  logic [7:0]        rx_data,
  input  logic              clear,
  output logic [DATA_W-1:0] value,
  output logic              value_valid,
  output logic              err_char,
  output logic              err_len,
  output logic              err_timeout,
  output logic              busy,
  output logic [6:0]        char_count
);

  localparam logic [6:0] FULL = 7'(NCHARS);

  state_t            state, state_d;
  logic              rx_done_q;
  logic [DATA_W-1:0] shreg, shreg_d, value_d;
  logic [6:0]        count_d;
  logic [31:0]       timer, timer_d;
  logic              vv_d, ec_d, el_d, et_d;
  logic              accept, timeout_hit;
  logic [3:0]        nib;
  logic              is_hex;

  ascii_hex_nibble u_nib (
    .ch     (rx_data),
    .nib    (nib),
    .is_hex (is_hex)
  );

  assign accept      = rx_done & ~rx_done_q;
  assign busy        = (char_count != 7'd0) || (state == S_DRAIN);
  assign timeout_hit = (TIMEOUT != 32'd0) && busy && (timer == TIMEOUT - 32'd1);

  always_comb begin
    state_d = state;
    count_d = char_count;
    shreg_d = shreg;
    value_d = value;
    vv_d    = 1'b0;
    ec_d    = 1'b0;
    el_d    = 1'b0;
    et_d    = 1'b0;
    timer_d = busy ? timer + 32'd1 : 32'd0;

    if (clear) begin
      state_d = S_COLLECT;
      count_d = 7'd0;
      timer_d = 32'd0;
    end else if (accept) begin
      // A byte in the timeout cycle takes precedence over the timeout.
      timer_d = 32'd0;
      if (rx_data == ASCII_CR) begin
        state_d = state;
      end else if (state == S_DRAIN) begin
        if (rx_data == ASCII_LF) state_d = S_COLLECT;
      end else if (is_hex) begin
        if (char_count == FULL) begin
          el_d    = 1'b1;
          count_d = 7'd0;
          state_d = S_DRAIN;
        end else begin
          shreg_d = {shreg[DATA_W-5:0], nib};
          count_d = char_count + 7'd1;
        end
      end else if (rx_data == ASCII_LF) begin
        if (char_count == FULL) begin
          value_d = shreg;
          vv_d    = 1'b1;
        end else if (char_count != 7'd0) begin
          el_d = 1'b1;
        end
        count_d = 7'd0;
      end else begin
        ec_d    = 1'b1;
        count_d = 7'd0;
        state_d = S_DRAIN;
      end
    end else if (timeout_hit) begin
      et_d    = 1'b1;
      count_d = 7'd0;
      state_d = S_COLLECT;
      timer_d = 32'd0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= S_COLLECT;
      rx_done_q   <= 1'b1;
      char_count  <= 7'd0;
      shreg       <= '0;
      value       <= '0;
      timer       <= 32'd0;
      value_valid <= 1'b0;
      err_char    <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_d;
      rx_done_q   <= rx_done;
      char_count  <= count_d;
      shreg       <= shreg_d;
      value       <= value_d;
      timer       <= timer_d;
      value_valid <= vv_d;
      err_char    <= ec_d;
      err_len     <= el_d;
      err_timeout <= et_d;
    end
  end

endmodule

// File: tb/tb_uart_hex_digest_rx.sv
// Randomized bench for uart_hex_digest_rx against a line-level reference model.
module tb_uart_hex_digest_rx;

  localparam int NCHARS = 64;
  localparam int TO     = 100;
  localparam logic [255:0] DIGEST =
    256'hc6e693d0a7f2b4c1e5d8093a6b1c2d3e4f5a6b7c8d9e0f1a2b3c4d5e630f8917;
  localparam int EV_VALID = 1, EV_CHAR = 2, EV_LEN = 3, EV_TIMEOUT = 4;

  logic         Clk = 1'b0;
  logic         Rst_n = 1'b0;
  logic         rx_done = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         clear = 1'b0;
  logic [255:0] value;
  logic         value_valid, err_char, err_len, err_timeout, busy;
  logic [6:0]   char_count;

  uart_hex_digest_rx #(.NCHARS(NCHARS), .TIMEOUT(32'(TO))) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .rx_done     (rx_done),
    .rx_data     (rx_data),
    .clear       (clear),
    .value       (value),
    .value_valid (value_valid),
    .err_char    (err_char),
    .err_len     (err_len),
    .err_timeout (err_timeout),
    .busy        (busy),
    .char_count  (char_count)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Observed pulses, in order.
  int           obs_code[$];
  logic [255:0] obs_val[$];
  int           npulse;

  always @(negedge Clk) begin
    if (Rst_n) begin
      npulse = int'(value_valid) + int'(err_char) + int'(err_len) + int'(err_timeout);
      if (npulse > 1) check_eq("onehot_pulses", 256'(npulse), 256'd1);
      if (value_valid) begin obs_code.push_back(EV_VALID);   obs_val.push_back(value); end
      if (err_char)    begin obs_code.push_back(EV_CHAR);    obs_val.push_back('0);    end
      if (err_len)     begin obs_code.push_back(EV_LEN);     obs_val.push_back('0);    end
      if (err_timeout) begin obs_code.push_back(EV_TIMEOUT); obs_val.push_back('0);    end
    end
  end

  // Reference model: one line at a time, digits folded arithmetically.
  int           m_cnt = 0;
  bit           m_drain = 1'b0;
  logic [255:0] m_acc = '0;
  logic [255:0] m_value = '0;
  int           last_acc = 0;
  int           exp_code[$];
  logic [255:0] exp_val[$];

  function automatic int hexval(input logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - 48;
    if (b >= "a" && b <= "f") return int'(b) - 87;
    if (b >= "A" && b <= "F") return int'(b) - 55;
    return -1;
  endfunction

  function automatic bit m_busy();
    return (m_cnt != 0) || m_drain;
  endfunction

  task automatic push_exp(input int code, input logic [255:0] v);
    exp_code.push_back(code);
    exp_val.push_back(v);
  endtask

  // Timeout fires TO edges after the last accept if the line is still open.
  task automatic model_flush();
    if (m_busy() && cyc >= last_acc + TO) begin
      push_exp(EV_TIMEOUT, '0);
      m_cnt   = 0;
      m_drain = 1'b0;
    end
  endtask

  task automatic model_accept(input logic [7:0] b, input int at);
    int h;
    if (m_busy() && at > last_acc + TO) begin
      push_exp(EV_TIMEOUT, '0);
      m_cnt   = 0;
      m_drain = 1'b0;
    end
    last_acc = at;
    h = hexval(b);
    if (b == 8'h0D) return;
    if (m_drain) begin
      if (b == 8'h0A) m_drain = 1'b0;
    end else if (h >= 0) begin
      if (m_cnt == NCHARS) begin
        push_exp(EV_LEN, '0);
        m_cnt   = 0;
        m_drain = 1'b1;
      end else begin
        m_acc = m_acc * 16 + 256'(h);
        m_cnt++;
      end
    end else if (b == 8'h0A) begin
      if (m_cnt == NCHARS) begin
        m_value = m_acc;
        push_exp(EV_VALID, m_value);
      end else if (m_cnt != 0) begin
        push_exp(EV_LEN, '0);
      end
      m_cnt = 0;
    end else begin
      push_exp(EV_CHAR, '0);
      m_cnt   = 0;
      m_drain = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    model_accept(b, cyc + 1);
    rx_data = b;
    rx_done = 1'b1;
    repeat (hold) @(negedge Clk);
    rx_done = 1'b0;
    repeat (gap) @(negedge Clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i], $urandom_range(1, 3), $urandom_range(1, 3));
  endtask

  task automatic compare_events(input string tag);
    int n;
    repeat (3) @(negedge Clk);
    #1;
    model_flush();
    check_eq({tag, "_nevents"}, 256'(obs_code.size()), 256'(exp_code.size()));
    n = (obs_code.size() < exp_code.size()) ? obs_code.size() : exp_code.size();
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_evcode"}, 256'(obs_code[i]), 256'(exp_code[i]));
      if (exp_code[i] == EV_VALID) check_eq({tag, "_evvalue"}, obs_val[i], exp_val[i]);
    end
    check_eq({tag, "_value"}, value, m_value);
    check_eq({tag, "_count"}, 256'(char_count), 256'(m_cnt));
    check_eq({tag, "_busy"}, 256'(busy), 256'(m_busy()));
    obs_code.delete(); obs_val.delete();
    exp_code.delete(); exp_val.delete();
  endtask

  function automatic logic [7:0] rand_hex(input bit upper);
    int v;
    v = $urandom_range(0, 15);
    if (v < 10) return 8'(48 + v);
    return upper ? 8'(55 + v) : 8'(87 + v);
  endfunction

  function automatic logic [7:0] rand_bad();
    logic [7:0] b;
    do b = 8'($urandom_range(0, 255));
    while (hexval(b) >= 0 || b == 8'h0A || b == 8'h0D);
    return b;
  endfunction

  logic [7:0] bq[$];
  string      s1, s2;
  int         kind, len;

  initial begin
    s1 = "c6e693d0a7f2b4c1e5d8093a6b1c2d3e4f5a6b7c8d9e0f1a2b3c4d5e630f8917";
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    check_eq("reset_value", value, '0);
    check_eq("reset_count", 256'(char_count), 256'd0);
    check_eq("reset_busy", 256'(busy), 256'd0);
    check_eq("reset_pulses", 256'({value_valid, err_char, err_len, err_timeout}), 256'd0);
    last_acc = cyc;

    send_str({s1, "\n"});
    compare_events("t1_lower");
    check_eq("t1_digest", value, DIGEST);

    s2 = s1.toupper();
    send_str({s2, "\r\n"});
    compare_events("t2_upper_cr");
    check_eq("t2_digest", value, DIGEST);

    send_str({s1.substr(0, 62), "\n"});
    compare_events("t3_short");
    check_eq("t3_value_held", value, DIGEST);
    send_str({s1, "5\n"});
    compare_events("t3_long");

    send_str("12g4\n");
    send_str({s2.substr(32, 63), s2.substr(0, 31), "\n"});
    compare_events("t4_badchar");

    send_str("0123456789");
    repeat (TO + 10) @(negedge Clk);
    compare_events("t5_timeout");
    check_eq("t5_busy", 256'(busy), 256'd0);
    send_str("abcd");
    send_byte("e", 1, TO - 1);          // next accept exactly TO edges later
    send_byte("f", 1, TO);              // next accept TO+1 edges later
    send_str("1\n");
    compare_events("t5_boundary");

    send_byte("7", 20, 2);
    check_eq("t6_hold_count", 256'(char_count), 256'd1);
    send_str("89");
    model_flush();
    clear = 1'b1;
    @(negedge Clk);
    clear = 1'b0;
    m_cnt = 0; m_drain = 1'b0;
    #1;
    check_eq("t6_clear_count", 256'(char_count), 256'd0);
    send_str("ab");
    model_flush();
    clear = 1'b1; rx_data = "c"; rx_done = 1'b1;
    @(negedge Clk);
    clear = 1'b0;
    m_cnt = 0; m_drain = 1'b0;
    @(negedge Clk);
    rx_done = 1'b0;
    @(negedge Clk);
    send_str("\n");
    compare_events("t6_clear");

    send_str("3456");
    rx_data = "7"; rx_done = 1'b1; Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    m_cnt = 0; m_drain = 1'b0; m_value = '0;
    repeat (3) @(negedge Clk);
    rx_done = 1'b0;
    @(negedge Clk);
    compare_events("t6_reset");

    for (int line = 0; line < 40; line++) begin
      kind = $urandom_range(0, 9);
      bq.delete();
      len = (kind == 5) ? $urandom_range(1, 63) : (kind == 6) ? $urandom_range(65, 70) :
            (kind == 8) ? 0 : 64;
      for (int i = 0; i < len; i++) bq.push_back(rand_hex(1'($urandom_range(0, 1))));
      if (kind == 7) bq[$urandom_range(0, 63)] = rand_bad();
      if (kind == 9) for (int i = 0; i < 4; i++) bq.insert($urandom_range(0, bq.size()), 8'h0D);
      bq.push_back(8'h0A);
      foreach (bq[i])
        send_byte(bq[i], $urandom_range(1, 3),
                  ($urandom_range(0, 59) == 0) ? $urandom_range(TO - 6, TO + 4) : $urandom_range(1, 3));
      compare_events("rand_line");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
